// File: rtl/ysyx_24100005_mem_responder.sv
// ysyx_24100005_mem_responder: multi-cycle word memory for the NPC load/store port.
// Each request is committed once its latency expires; the response is held until rsp_ready.
module ysyx_24100005_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  WAIT  = 2'd1;
  localparam logic [1:0]  RESP  = 2'd2;
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << DEPTH_LOG2);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be within 1..15");
  end
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_wen;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wmask;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [2**DEPTH_LOG2];
  logic                  w_idle;
  logic                  w_commit;
  logic                  w_wen;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wmask;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  // With LATENCY==1 the commit happens on the accept edge, straight from the request inputs.
  assign w_idle    = r_state == IDLE;
  assign w_commit  = w_idle ? (req_valid && LATENCY == 1) : (r_state == WAIT && r_cnt == 4'd1);
  assign w_wen     = w_idle ? req_wen   : r_wen;
  assign w_addr    = w_idle ? req_addr  : r_addr;
  assign w_wdata   = w_idle ? req_wdata : r_wdata;
  assign w_wmask   = w_idle ? req_wmask : r_wmask;
  assign w_err     = w_addr < BASE || {1'b0, w_addr} >= LIMIT;
  assign w_idx     = DEPTH_LOG2'((w_addr - BASE) >> 2);
  assign req_ready = w_idle;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_idle && req_valid) begin
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_commit) begin
        r_state <= RESP;
        r_err   <= w_err;
        r_rdata <= (w_err || w_wen) ? 32'd0 : r_mem[w_idx];
      end else if (w_idle && req_valid) r_state <= WAIT;
      else if (r_state == RESP && rsp_ready) begin
        r_state <= IDLE;
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end
  // The array has no reset; a request aborted by rst must never land in it.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_wen && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ysyx_24100005_mem_responder.sv
// tb_ysyx_24100005_mem_responder: scoreboard bench for a LATENCY=2 and a LATENCY=1 responder.
module tb_ysyx_24100005_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req_valid = 1'b0, a_req_ready, a_req_wen = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_wmask = '0;
  logic        a_rsp_valid, a_rsp_ready = 1'b1, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid = 1'b0, b_req_ready, b_req_wen = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_wmask = '0;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [32:0] qa[$], qb[$];
  logic [32:0] ea, eb;
  int          total = 0, bad = 0, cyc = 0, b_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_24100005_mem_responder #(.LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  ysyx_24100005_mem_responder #(.LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_rsp_valid && a_rsp_ready) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        chk("a_rdata", a_rsp_rdata, ea[32:1]);
        chk("a_err", 32'(a_rsp_err), 32'(ea[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rsp_valid) begin
      if (qb.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        chk("b_rdata", b_rsp_rdata, eb[32:1]);
        chk("b_err", 32'(b_rsp_err), 32'(eb[0]));
      end
      if (b_last != 0) chk("b_spacing", 32'(cyc - b_last), 32'd2);
      b_last = cyc;
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_a_req_ready"}, 32'(a_req_ready), 32'd1);
    chk({nm, "_a_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
    chk({nm, "_a_rsp_rdata"}, a_rsp_rdata, 32'd0);
    chk({nm, "_a_rsp_err"}, 32'(a_rsp_err), 32'd0);
    chk({nm, "_b_req_ready"}, 32'(b_req_ready), 32'd1);
    chk({nm, "_b_rsp_valid"}, 32'(b_rsp_valid), 32'd0);
  endtask

  // One transaction on the LATENCY=2 instance; called #1 after an edge with the DUT idle.
  task automatic xa(input bit w, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] m,
                    input logic [31:0] er, input bit ee, input int hold);
    int n;
    a_req_valid = 1'b1; a_req_wen = w; a_req_addr = ad; a_req_wdata = d; a_req_wmask = m;
    a_rsp_ready = (hold == 0);
    qa.push_back({er, ee});
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_wen = 1'($urandom); a_req_addr = $urandom;
    a_req_wdata = $urandom; a_req_wmask = 4'($urandom);
    n = 1;
    while (!a_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("a_latency", 32'(n), 32'd2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("hold_rsp_rdata", a_rsp_rdata, er);
      chk("hold_rsp_err", 32'(a_rsp_err), 32'(ee));
      chk("hold_req_ready", 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("a_idle_after_rsp", 32'(a_req_ready), 32'd1);
  endtask

  // One streamed request on the LATENCY=1 instance; req_valid stays high between calls.
  task automatic bs(input bit w, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] m,
                    input logic [31:0] er, input bit ee);
    bit acc;
    int n;
    b_req_valid = 1'b1; b_req_wen = w; b_req_addr = ad; b_req_wdata = d; b_req_wmask = m;
    qb.push_back({er, ee});
    n = 0;
    do begin
      acc = b_req_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 10);
    chk("b_accept", 32'(acc), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    xa(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    xa(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xa(1, 32'h8000_0010, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0, 0);
    xa(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
    xa(0, 32'h8000_0013, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
    xa(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xa(0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xa(1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 0);
    xa(1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 0);
    xa(0, 32'h8000_0000, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);
    xa(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0);
    xa(0, 32'h8000_0000, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);
    xa(1, 32'h8000_0FFC, 32'h5A5A_A5A5, 4'hF, 32'h0, 1'b0, 0);
    xa(0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h5A5A_A5A5, 1'b0, 0);
    xa(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 5);
    xa(1, 32'h8000_0020, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 0);
    a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 32'h8000_0020;
    a_req_wdata = 32'h2222_2222; a_req_wmask = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    chk("abort_in_wait", 32'(a_req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk_reset_outputs("mid_rst_edge");
    rst = 1'b0;
    @(posedge clk); #1;
    xa(0, 32'h8000_0020, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 0);
    bs(1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
    bs(1, 32'h8000_0004, 32'hA0B0_C0D0, 4'hF, 32'h0, 1'b0);
    bs(1, 32'h8000_0004, 32'h0000_00EE, 4'b0001, 32'h0, 1'b0);
    bs(0, 32'h8000_0000, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
    bs(0, 32'h8000_0007, 32'h0, 4'h0, 32'hA0B0_C0EE, 1'b0);
    bs(0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1);
    bs(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1);
    b_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
